// File: rtl/apb_req_arbiter_if.sv
// Bundle between the requester/APB-monitor side and the round-robin APB request arbiter.
// The arbiter connects through the slave modport; the driving environment uses master.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    req_write_i;
  logic [NUM_REQ*DW-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    done_o;
  logic [DW-1:0]         rdata_o;
  logic                  err_o;
  logic [1:0]            cmd_o;
  logic [DW-1:0]         wdata_o;
  logic                  apb_psel_i;
  logic                  apb_penable_i;
  logic                  apb_pready_i;
  logic [DW-1:0]         apb_prdata_i;
  logic                  apb_pslverr_i;

  modport slave (
    input  req_i, req_write_i, req_wdata_i,
    input  apb_psel_i, apb_penable_i, apb_pready_i, apb_prdata_i, apb_pslverr_i,
    output gnt_o, done_o, rdata_o, err_o, cmd_o, wdata_o
  );

  modport master (
    output req_i, req_write_i, req_wdata_i,
    output apb_psel_i, apb_penable_i, apb_pready_i, apb_prdata_i, apb_pslverr_i,
    input  gnt_o, done_o, rdata_o, err_o, cmd_o, wdata_o
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin front-end sharing one APB master between NUM_REQ requesters: issues a
// one-cycle command, watches the bus for completion, then pulses done to the winner.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32
) (
  input  logic               pclk,
  input  logic               preset_n,
  apb_req_arbiter_if.slave   bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [IW-1:0]   last_reg, last_next;
  logic            write_reg, write_next;
  logic            err_reg, err_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [DW-1:0]   rdata_reg, rdata_next;

  logic [IW-1:0]   cand_idx [NUM_REQ];
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            xfer_done;
  logic [NUM_REQ-1:0] sel_onehot;

  // Candidate gi is last_reg+gi+1 modulo NUM_REQ; the sum never exceeds 2*NUM_REQ-1.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    localparam int OFF = gi + 1;
    logic [IW:0] sum;
    assign sum = {1'b0, last_reg} + (IW+1)'(OFF);
    assign cand_idx[gi] = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
  end

  // Scan farthest-first so the nearest requesting candidate overwrites the result.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_i[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign xfer_done = bus.apb_psel_i & bus.apb_penable_i & bus.apb_pready_i;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    write_next = write_reg;
    err_next   = err_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          last_next  = pick_idx;
          write_next = bus.req_write_i[pick_idx];
          wdata_next = bus.req_wdata_i[int'(pick_idx)*DW +: DW];
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (xfer_done) begin
          err_next = bus.apb_pslverr_i;
          if (!write_reg) rdata_next = bus.apb_prdata_i;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      last_reg  <= IW'(NUM_REQ - 1);
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      write_reg <= write_next;
      err_reg   <= err_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  assign sel_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_reg;
  assign bus.gnt_o   = (state_reg != IDLE) ? sel_onehot : '0;
  assign bus.done_o  = (state_reg == RESP) ? sel_onehot : '0;
  assign bus.err_o   = (state_reg == RESP) & err_reg;
  assign bus.cmd_o   = (state_reg == ISSUE) ? {write_reg, 1'b1} : 2'b00;
  assign bus.wdata_o = (state_reg != IDLE) ? wdata_reg : '0;
  assign bus.rdata_o = rdata_reg;
endmodule
